// File: rtl/median_pkg.sv
// Shared definitions for the median filter datapath: sequencer state
// encoding, default window size and the sample width used by MED.
package median_pkg;

  localparam int DEF_NUMBER = 9;                  // samples per window (odd, >= 3)
  localparam int DEF_PASSES = (DEF_NUMBER - 1) / 2; // full sort passes
  localparam int WIDTH      = 8;                  // sample width, shared with MED

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SORT,
    FINAL,
    DONE
  } state_t;

endpackage

// File: rtl/median_ctrl_if.sv
// Control bundle between the window source, the sequencer and MED.
//
// Strobe semantics: DSI is a qualifier with no back-pressure. A window is
// DSI held high for NUMBER consecutive cycles; each high cycle carries one
// sample on MED.DI. The sequencer forwards the strobe combinationally as
// MED_DSI while loading, drives MED_BYP for the sort schedule, and raises
// DSO for exactly one cycle when MED.DO holds the median. ERR is a one-cycle
// flag for a short or overlong window; BUSY covers first sample to DSO.
interface median_ctrl_if;

  logic DSI;
  logic MED_DSI;
  logic MED_BYP;
  logic DSO;
  logic BUSY;
  logic ERR;

  modport master (
    input  DSI,
    output MED_DSI, MED_BYP, DSO, BUSY, ERR
  );

  modport slave (
    output DSI,
    input  MED_DSI, MED_BYP, DSO, BUSY, ERR
  );

endinterface

// File: rtl/median_ctrl.sv
// Sequencer for the serial median core: loads a window of NUMBER samples,
// runs PASSES compare/rotate passes plus a final compare tail, then flags
// the median on DSO. Purely control; no sample data passes through here.
module median_ctrl
  import median_pkg::*;
#(
  parameter int NUMBER = DEF_NUMBER
) (
  input  logic                 CLK,
  input  logic                 RST,
  median_ctrl_if.master        bus,
  output state_t               dbg_state
);

  localparam int PASSES    = (NUMBER - 1) / 2;
  localparam int CW        = $clog2(NUMBER + 1);
  localparam int PW        = $clog2(PASSES + 1);
  localparam int FINAL_LEN = NUMBER - 1 - PASSES;

  localparam logic [CW-1:0] LAST_IDX   = CW'(NUMBER - 1);
  localparam logic [CW-1:0] FINAL_LAST = CW'(FINAL_LEN - 1);
  localparam logic [PW-1:0] LAST_PASS  = PW'(PASSES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] load_cnt, load_cnt_nx;
  logic [CW-1:0] step, step_nx;
  logic [PW-1:0] pass, pass_nx;
  logic          err_q, err_nx;
  // Low only in the first cycle after reset release, so a strobe seen
  // then is not forwarded while outputs must still hold reset values.
  logic          armed;

  // State, counters and the registered error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      load_cnt <= '0;
      step     <= '0;
      pass     <= '0;
      err_q    <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= state_nx;
      load_cnt <= load_cnt_nx;
      step     <= step_nx;
      pass     <= pass_nx;
      err_q    <= err_nx;
      armed    <= 1'b1;
    end
  end

  // Next-state, counter updates and the MED control outputs.
  always_comb begin
    state_nx    = state;
    load_cnt_nx = load_cnt;
    step_nx     = step;
    pass_nx     = pass;
    err_nx      = 1'b0;
    bus.MED_DSI = 1'b0;
    bus.MED_BYP = 1'b1;
    bus.DSO     = 1'b0;
    bus.BUSY    = 1'b0;

    case (state)
      IDLE: begin
        if (armed) begin
          bus.MED_DSI = bus.DSI;
          bus.BUSY    = bus.DSI;
          if (bus.DSI) begin
            load_cnt_nx = CW'(1);
            state_nx    = LOAD;
          end
        end
      end

      LOAD: begin
        bus.BUSY    = 1'b1;
        bus.MED_DSI = bus.DSI;
        if (bus.DSI) begin
          if (load_cnt == LAST_IDX) begin
            load_cnt_nx = '0;
            step_nx     = '0;
            pass_nx     = '0;
            state_nx    = SORT;
          end else begin
            load_cnt_nx = load_cnt + CW'(1);
          end
        end else begin
          // Window ended early: drop it and flag the error next cycle.
          err_nx      = 1'b1;
          load_cnt_nx = '0;
          state_nx    = IDLE;
        end
      end

      SORT: begin
        bus.BUSY    = 1'b1;
        // Pass p compares the first NUMBER-1-p positions, rotates the rest.
        bus.MED_BYP = !(step < (LAST_IDX - CW'(pass)));
        // A strobe right after the last sample means the window was too long.
        if (bus.DSI && (pass == '0) && (step == '0))
          err_nx = 1'b1;
        if (step == LAST_IDX) begin
          step_nx = '0;
          if (pass == LAST_PASS) begin
            pass_nx  = '0;
            state_nx = FINAL;
          end else begin
            pass_nx = pass + PW'(1);
          end
        end else begin
          step_nx = step + CW'(1);
        end
      end

      FINAL: begin
        bus.BUSY    = 1'b1;
        bus.MED_BYP = 1'b0;
        if (step == FINAL_LAST) begin
          step_nx  = '0;
          state_nx = DONE;
        end else begin
          step_nx = step + CW'(1);
        end
      end

      DONE: begin
        bus.BUSY = 1'b1;
        bus.DSO  = 1'b1;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  assign bus.ERR   = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_median_ctrl.sv
// Bench for median_ctrl: a per-cycle scoreboard fed by a window-level
// reference model of the load/sort/final/done schedule.
module tb_median_ctrl;
  import median_pkg::*;

  localparam int N = DEF_NUMBER;
  localparam int P = (N - 1) / 2;
  localparam int W = 5;  // {MED_DSI, MED_BYP, DSO, BUSY, ERR}

  localparam logic [W-1:0] IDLE_W  = 5'b01000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  median_ctrl_if bus();
  state_t dbg_state;

  median_ctrl #(.NUMBER(N)) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit           seq_q[$];
  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Walks the strobe sequence window by window and writes the expected
  // output word for every cycle.
  task automatic build_model();
    int n, i, r, cyc;
    bit err_a[];
    n = seq_q.size();
    err_a = new[n + 2];
    model_q.delete();
    for (int k = 0; k < n; k++) model_q.push_back(IDLE_W);
    i = 0;
    while (i < n) begin
      if (!seq_q[i]) begin
        i++;
        continue;
      end
      r = 0;
      while ((i + r < n) && seq_q[i + r] && (r <= N)) r++;
      if (r < N) begin
        for (int k = 0; k < r; k++) model_q[i + k] = 5'b11010;
        model_q[i + r] = 5'b01010;
        err_a[i + r + 1] = 1'b1;
        i = i + r + 1;
      end else begin
        for (int k = 0; k < N; k++) model_q[i + k] = 5'b11010;
        cyc = i + N;
        if (seq_q[cyc]) err_a[cyc + 1] = 1'b1;
        for (int p = 0; p < P; p++)
          for (int s = 0; s < N; s++) begin
            model_q[cyc] = {1'b0, (s >= N - 1 - p), 3'b010};
            cyc++;
          end
        for (int f = 0; f < N - 1 - P; f++) begin
          model_q[cyc] = 5'b00010;
          cyc++;
        end
        model_q[cyc] = 5'b01110;
        cyc++;
        i = cyc;
      end
    end
    for (int k = 0; k < n; k++) model_q[k][0] = err_a[k];
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_bits(input bit v, input int cnt);
    for (int k = 0; k < cnt; k++) seq_q.push_back(v);
  endtask

  // Drive the built sequence (padded so every window completes); stop_at
  // >= 0 truncates the run for the reset-abort case.
  task automatic run_seq(input int stop_at);
    int lim;
    add_bits(1'b0, 60);
    build_model();
    lim = (stop_at >= 0) ? stop_at : seq_q.size();
    for (int k = 0; k < lim; k++) begin
      @(posedge clk);
      #1;
      bus.DSI = seq_q[k];
      exp_q.push_back(model_q[k]);
    end
    @(posedge clk);
    #1;
    bus.DSI = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d words left, expected 0", exp_q.size());
      exp_q.delete();
    end
    seq_q.delete();
  endtask

  task automatic check_reset(input string name);
    logic [W-1:0] got;
    got = {bus.MED_DSI, bus.MED_BYP, bus.DSO, bus.BUSY, bus.ERR};
    n_checks++;
    if (got !== IDLE_W) begin
      n_fail++;
      $display("FAIL %s outputs: got %b expected %b", name, got, IDLE_W);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL %s state: got %0d expected %0d", name, dbg_state, IDLE);
    end
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset(name);
    bus.DSI = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [W-1:0] got, want;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {bus.MED_DSI, bus.MED_BYP, bus.DSO, bus.BUSY, bus.ERR};
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL cycle_out t=%0t: got %b expected %b (dsi,byp,dso,busy,err)",
                   $time, got, want);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int nw, r;
    bus.DSI = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset("reset_initial");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Nominal window.
    add_bits(1'b0, 2);
    add_bits(1'b1, N);
    run_seq(-1);

    // Short window, then a good one.
    add_bits(1'b0, 2);
    add_bits(1'b1, 5);
    add_bits(1'b0, 3);
    add_bits(1'b1, N);
    run_seq(-1);

    // Overlong window, strobe during DONE, then back-to-back window.
    add_bits(1'b0, 2);
    add_bits(1'b1, N + 1);
    add_bits(1'b0, 39);
    add_bits(1'b1, N + 1);
    run_seq(-1);

    // Reset during pass 2, then a fresh window.
    add_bits(1'b0, 2);
    add_bits(1'b1, N);
    run_seq(2 + N + 2 * N + 1);
    async_reset("reset_mid_sort");
    add_bits(1'b0, 2);
    add_bits(1'b1, N);
    run_seq(-1);

    // Randomised window mixes.
    for (int seg = 0; seg < 12; seg++) begin
      add_bits(1'b0, 2);
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        add_bits(1'b0, $urandom_range(0, 4));
        r = $urandom_range(0, 9);
        if (r < 3)      add_bits(1'b1, $urandom_range(1, N - 1));
        else if (r < 8) add_bits(1'b1, N);
        else            add_bits(1'b1, $urandom_range(N + 1, N + 4));
      end
      run_seq(-1);
    end

    // Fully random strobe sequences.
    for (int seg = 0; seg < 3; seg++) begin
      add_bits(1'b0, 2);
      for (int k = 0; k < 60; k++) add_bits(1'($urandom_range(0, 1)), 1);
      run_seq(-1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/median_ctrl.md
Name: median_ctrl

Overview:
- Sequencer for the serial median core (MED) in the median filter datapath.
- Accepts a window of NUMBER samples on the upstream DSI strobe and drives the core's DSI/BYP controls through the fixed load/sort schedule.
- Pulses DSO when the core's DO holds the median; sits between the pixel-window source and MED, sharing its clock.
- Purely control: samples never pass through this block.

Parameters:
- NUMBER, 9, samples per window; odd, >=3; must equal MED's number.
- PASSES (localparam), (NUMBER-1)/2, full sort passes; 4 for the default.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- DSI  input  1  upstream sample strobe; high for NUMBER consecutive cycles per window, in step with DI on MED.
- MED_DSI  output  1  to MED.DSI: load DI into the core this cycle.
- MED_BYP  output  1  to MED.BYP: 1 = rotate without compare, 0 = compare-exchange.
- DSO  output  1  one-cycle pulse: MED.DO is the median of the window this cycle.
- BUSY  output  1  high from first loaded sample until the DSO cycle inclusive.
- ERR  output  1  one-cycle pulse on protocol violation (short or overlong window).

Behaviour:
- Reset (async, RST=1): state IDLE, all counters 0. MED_DSI=0, MED_BYP=1, DSO=0, BUSY=0, ERR=0 while RST is high and in the first cycle after release.
- State encoding: enum in package, states IDLE, LOAD, SORT, FINAL, DONE.
- IDLE:
  - MED_BYP=1 and MED_DSI=DSI (combinational, so the sample enters MED in the same cycle).
  - DSI=1 -> load_cnt=1, go LOAD, BUSY=1 from this cycle.
- LOAD:
  - MED_DSI=DSI, MED_BYP=1.
  - DSI=1 increments load_cnt.
  - When the cycle with load_cnt=NUMBER-1 has DSI=1, that is the NUMBER-th sample; next state SORT with pass=0, step=0.
  - DSI=0 before NUMBER samples: MED_DSI=0, ERR pulse next cycle, window discarded, return to IDLE.
- SORT:
  - MED_DSI=0; pass p in 0..PASSES-1, step s in 0..NUMBER-1.
  - MED_BYP=0 when s < NUMBER-1-p, else 1.
  - s wraps to 0 and p increments after s=NUMBER-1.
  - After p=PASSES-1, s=NUMBER-1, go FINAL.
- FINAL:
  - MED_DSI=0, MED_BYP=0 for NUMBER-1-PASSES cycles (4 by default), then go DONE.
- DONE:
  - One cycle: DSO=1, MED_DSI=0, MED_BYP=1, BUSY=1; next state IDLE.
- Latency: last load cycle L -> DSO at L + PASSES*NUMBER + (NUMBER-1-PASSES) + 1 = L+41 for the default.
- Overlong window:
  - DSI=1 in the first SORT cycle (a 10th consecutive sample): ERR pulse, sample ignored (MED_DSI=0), sorting continues unaffected.
  - DSI=1 at any later point in SORT/FINAL/DONE: ignored, no ERR.
- Back-to-back windows:
  - DSI=1 in the cycle after DONE (state IDLE) starts a new window normally.
  - DSI=1 during DONE is ignored.
- Reset mid-operation: immediate return to IDLE with reset output values; no DSO for the aborted window.
- Counter widths: $clog2(NUMBER+1) for load_cnt and step; $clog2(PASSES+1) for pass. No counter wraps except step as defined.

Decomposition:
- Shared package median_pkg holds:
  - state enum;
  - default NUMBER=9 and derived PASSES;
  - WIDTH=8 shared with MED.
- Single module; no sub-module. One always_ff for state and counters, one always_comb for next state and outputs.
- Optional: a top-level integration module instantiates median_ctrl with MED; that module is not part of this block.

Test Plan:
- Reset: assert RST mid-cycle with no clock edge -> outputs go to MED_DSI=0, MED_BYP=1, DSO=0, BUSY=0, ERR=0 immediately.
- Nominal window:
  - DSI high 9 cycles (t0..t8) -> MED_DSI high t0..t8, MED_BYP=1 t0..t8.
  - Pass 0 BYP pattern 0×8,1×1; pass 3 pattern 0×5,1×4; FINAL 0×4.
  - DSO single pulse at t49; BUSY high t0..t49.
- Integrated with MED, window 9,3,7,1,5,8,2,6,4 -> DO=5 while DSO=1; window 255×9 -> DO=255.
- Short window: DSI high 5 cycles then low -> ERR pulse one cycle later, return to IDLE, no DSO; a following 9-sample window sorts correctly.
- Overlong and back-to-back:
  - DSI high 10 cycles -> ERR pulse once, DSO still at L+41.
  - Second window starting the cycle after DSO -> second DSO exactly 50 cycles after the first.
- Reset at pass 2 -> no DSO, BUSY=0; a new window after release yields a correct median.
